// File: rtl/branch_predict_unit.sv
// Branch unit: fetch-stage BHT prediction plus EX-stage resolution, training and statistics.
// Latency: prediction and resolution are combinational (0 cycles); training is visible to fetch one cycle after the EX edge.
// Backpressure: none; the unit accepts one fetch lookup and one EX resolution every cycle and never stalls.
module branch_predict_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH),
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  output logic              if_is_branch,
  output logic              if_pred_taken,
  output logic [PC_W-1:0]   if_pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [31:0]       ex_instr,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic              ex_pred_taken,
  output logic              ex_is_branch,
  output logic              ex_taken,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLEZ,
    BR_BGTZ,
    BR_BLTZ,
    BR_BGEZ
  } br_kind_e;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Classify an instruction word; REGIMM needs the rt field to tell BLTZ from BGEZ.
  function automatic br_kind_e decode_branch(input logic [31:0] instr);
    br_kind_e kind;
    kind = BR_NONE;
    case (instr[31:26])
      6'h04: kind = BR_BEQ;
      6'h05: kind = BR_BNE;
      6'h06: kind = BR_BLEZ;
      6'h07: kind = BR_BGTZ;
      6'h01: begin
        if (instr[20:16] == 5'h00)      kind = BR_BLTZ;
        else if (instr[20:16] == 5'h01) kind = BR_BGEZ;
        else                            kind = BR_NONE;
      end
      default: kind = BR_NONE;
    endcase
    return kind;
  endfunction

  // Two's-complement branch condition on the forwarded operands.
  function automatic logic branch_cond(input br_kind_e kind,
                                       input logic [DATA_W-1:0] rs,
                                       input logic [DATA_W-1:0] rt);
    logic rs_neg;
    logic rs_zero;
    logic res;
    rs_neg  = rs[DATA_W-1];
    rs_zero = (rs == '0);
    case (kind)
      BR_BEQ:  res = (rs == rt);
      BR_BNE:  res = (rs != rt);
      BR_BLEZ: res = rs_neg | rs_zero;
      BR_BGTZ: res = ~rs_neg & ~rs_zero;
      BR_BLTZ: res = rs_neg;
      BR_BGEZ: res = ~rs_neg;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // pc + 4 + (sext(imm16) << 2), wrapping at the PC width.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                    input logic [31:0] instr);
    logic [PC_W-1:0] off;
    off = {{(PC_W-16){instr[15]}}, instr[15:0]};
    return pc + PC_W'(4) + (off << 2);
  endfunction

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_upd_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  br_kind_e         if_kind;
  br_kind_e         ex_kind;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       if_ctr;
  logic [1:0]       ex_ctr;
  logic [PC_W-1:0]  if_tgt;
  logic [PC_W-1:0]  ex_tgt;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Fetch-side lookup straight from BHT registers; a same-cycle EX write is not bypassed.
  always_comb begin
    if_kind        = decode_branch(if_instr);
    if_ctr         = bht_q[if_idx];
    if_tgt         = branch_target(if_pc, if_instr);
    if_is_branch   = (if_kind != BR_NONE);
    if_pred_taken  = if_valid & if_is_branch & if_ctr[1];
    if_pred_target = if_pred_taken ? if_tgt : (if_pc + PC_W'(4));
  end

  // EX-side resolution: outcome, mispredict flag and the corrected next PC.
  always_comb begin
    ex_kind      = decode_branch(ex_instr);
    ex_tgt       = branch_target(ex_pc, ex_instr);
    ex_is_branch = ex_valid & (ex_kind != BR_NONE);
    ex_taken     = ex_is_branch & branch_cond(ex_kind, ex_rs, ex_rt);
    mispredict   = ex_is_branch & (ex_taken != ex_pred_taken);
    redirect_pc  = ex_taken ? ex_tgt : (ex_pc + PC_W'(4));
  end

  // Next value of the trained entry: saturating up on taken, down on not-taken.
  always_comb begin
    ex_ctr    = bht_q[ex_idx];
    bht_upd_d = ex_ctr;
    if (ex_taken) begin
      if (ex_ctr != 2'b11) bht_upd_d = ex_ctr + 2'b01;
    end else begin
      if (ex_ctr != 2'b00) bht_upd_d = ex_ctr - 2'b01;
    end
  end

  // Next values of the statistics counters, holding at all-ones rather than wrapping.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ex_is_branch && (branch_count_q != CNT_MAX))
      branch_count_d = branch_count_q + CNT_W'(1);
    if (mispredict && (mispredict_count_q != CNT_MAX))
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
  end

  // BHT storage: reset wipes all history to weak-not-taken, otherwise train on resolved branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_WEAK_NT;
    end else if (ex_is_branch) begin
      bht_q[ex_idx] <= bht_upd_d;
    end
  end

  // Statistics registers; counting is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a queue-based scoreboard.
// Stimulus drives one cycle of inputs #1 after the rising edge and pushes the expected outputs.
// A negedge monitor pops one expectation per cycle and compares every output field.
module tb_branch_predict_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_valid = 1'b0;
  logic [31:0]   if_pc = '0;
  logic [31:0]   if_instr = '0;
  logic          if_is_branch;
  logic          if_pred_taken;
  logic [31:0]   if_pred_target;
  logic          ex_valid = 1'b0;
  logic [31:0]   ex_pc = '0;
  logic [31:0]   ex_instr = '0;
  logic [31:0]   ex_rs = '0;
  logic [31:0]   ex_rt = '0;
  logic          ex_pred_taken = 1'b0;
  logic          ex_is_branch;
  logic          ex_taken;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  branch_predict_unit #(
    .DATA_W(32), .PC_W(32), .BHT_DEPTH(64), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_is_branch(if_is_branch), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_pred_taken(ex_pred_taken),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] v [9];
  } exp_t;

  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] act [9];
  string       fld [9] = '{"if_is_branch", "if_pred_taken", "if_pred_target", "ex_is_branch",
                           "ex_taken", "mispredict", "redirect_pc", "branch_count",
                           "mispredict_count"};

  // Encodings
  localparam logic [31:0] BEQ  = 32'h1000_0000;
  localparam logic [31:0] BNE  = 32'h1400_0000;
  localparam logic [31:0] BLEZ = 32'h1800_0000;
  localparam logic [31:0] BGTZ = 32'h1C00_0000;
  localparam logic [31:0] BLTZ = 32'h0400_0000;
  localparam logic [31:0] BGEZ = 32'h0401_0000;
  localparam logic [31:0] ADD  = 32'h0022_1820;

  task automatic drive(input bit rst, input bit ifv, input logic [31:0] ipc, input logic [31:0] iins,
                       input bit exv, input logic [31:0] epc, input logic [31:0] eins,
                       input logic [31:0] rs, input logic [31:0] rt, input bit pt);
    @(posedge clk);
    #1;
    reset = rst; if_valid = ifv; if_pc = ipc; if_instr = iins;
    ex_valid = exv; ex_pc = epc; ex_instr = eins; ex_rs = rs; ex_rt = rt; ex_pred_taken = pt;
  endtask

  task automatic expect_out(input string name, input bit ib, input bit ipt, input logic [31:0] itgt,
                            input bit eb, input bit et, input bit mp, input logic [31:0] rpc,
                            input int bc, input int mc);
    exp_t e;
    e.name = name;
    e.v = '{32'(ib), 32'(ipt), itgt, 32'(eb), 32'(et), 32'(mp), rpc, 32'(bc), 32'(mc)};
    sb.push_back(e);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      act = '{32'(if_is_branch), 32'(if_pred_taken), if_pred_target, 32'(ex_is_branch),
              32'(ex_taken), 32'(mispredict), redirect_pc, 32'(branch_count), 32'(mispredict_count)};
      for (int k = 0; k < 9; k++) begin
        n_cmp++;
        if (act[k] !== e.v[k]) begin
          n_bad++;
          $display("FAIL %s.%s: got 0x%0h expected 0x%0h", e.name, fld[k], act[k], e.v[k]);
        end
      end
    end
  end

  initial begin
    // Reset state: BHT reads weak-NT, counters zero.
    drive(1, 1, 32'h100, BEQ | 32'h4, 0, 0, 0, 0, 0, 0);
    expect_out("rst", 1, 0, 32'h104, 0, 0, 0, 32'h4, 0, 0);
    // First taken BEQ resolves against a not-taken prediction; fetch sees pre-update value.
    drive(0, 1, 32'h100, BEQ | 32'h4, 1, 32'h100, BEQ | 32'h4, 5, 5, 0);
    expect_out("beq_ex", 1, 0, 32'h104, 1, 1, 1, 32'h114, 0, 0);
    drive(0, 1, 32'h100, BEQ | 32'h4, 0, 0, 0, 0, 0, 0);
    expect_out("beq_trained", 1, 1, 32'h114, 0, 0, 0, 32'h4, 1, 1);
    // Condition coverage on distinct indices.
    drive(0, 0, 0, 0, 1, 32'h104, BGTZ | 32'h8, 0, 0, 0);
    expect_out("bgtz_zero", 0, 0, 32'h4, 1, 0, 0, 32'h108, 1, 1);
    drive(0, 0, 0, 0, 1, 32'h108, BLEZ | 32'h8, 0, 0, 1);
    expect_out("blez_zero", 0, 0, 32'h4, 1, 1, 0, 32'h12C, 2, 1);
    drive(0, 0, 0, 0, 1, 32'h110, BLTZ | 32'h8, 32'h8000_0000, 0, 0);
    expect_out("bltz_neg", 0, 0, 32'h4, 1, 1, 1, 32'h134, 3, 1);
    drive(0, 0, 0, 0, 1, 32'h114, BGEZ | 32'h8, 0, 0, 0);
    expect_out("bgez_zero", 0, 0, 32'h4, 1, 1, 1, 32'h138, 4, 2);
    drive(0, 0, 0, 0, 1, 32'h118, BNE | 32'h8, 1, 2, 1);
    expect_out("bne_diff", 0, 0, 32'h4, 1, 1, 0, 32'h13C, 5, 3);
    drive(0, 0, 0, 0, 1, 32'h118, BNE | 32'h8, 7, 7, 1);
    expect_out("bne_same", 0, 0, 32'h4, 1, 0, 1, 32'h11C, 6, 3);
    drive(0, 1, 32'h104, BGTZ | 32'h8, 0, 0, 0, 0, 0, 0);
    expect_out("bgtz_fetch", 1, 0, 32'h108, 0, 0, 0, 32'h4, 7, 4);
    // Saturation walk on index 7 with imm=-1 (target == pc): 01->10->11->11->11->10.
    drive(0, 1, 32'h11C, BEQ | 32'hFFFF, 1, 32'h11C, BEQ | 32'hFFFF, 0, 0, 0);
    expect_out("sat_t1", 1, 0, 32'h120, 1, 1, 1, 32'h11C, 7, 4);
    drive(0, 1, 32'h11C, BEQ | 32'hFFFF, 1, 32'h11C, BEQ | 32'hFFFF, 0, 0, 1);
    expect_out("sat_t2", 1, 1, 32'h11C, 1, 1, 0, 32'h11C, 8, 5);
    drive(0, 1, 32'h11C, BEQ | 32'hFFFF, 1, 32'h11C, BEQ | 32'hFFFF, 0, 0, 1);
    expect_out("sat_t3", 1, 1, 32'h11C, 1, 1, 0, 32'h11C, 9, 5);
    drive(0, 1, 32'h11C, BEQ | 32'hFFFF, 1, 32'h11C, BEQ | 32'hFFFF, 0, 0, 1);
    expect_out("sat_t4", 1, 1, 32'h11C, 1, 1, 0, 32'h11C, 10, 5);
    drive(0, 1, 32'h11C, BEQ | 32'hFFFF, 1, 32'h11C, BEQ | 32'hFFFF, 1, 0, 1);
    expect_out("sat_nt", 1, 1, 32'h11C, 1, 0, 1, 32'h120, 11, 5);
    drive(0, 1, 32'h11C, BEQ | 32'hFFFF, 0, 0, 0, 0, 0, 0);
    expect_out("sat_after", 1, 1, 32'h11C, 0, 0, 0, 32'h4, 12, 6);
    drive(0, 1, 32'h200, BEQ | 32'hFFFF, 0, 0, 0, 0, 0, 0);
    expect_out("neg_imm", 1, 1, 32'h200, 0, 0, 0, 32'h4, 12, 6);
    // Same-cycle write/read on index 3, then gated EX cases.
    drive(0, 1, 32'h10C, BEQ | 32'h4, 1, 32'h10C, BEQ | 32'h4, 3, 3, 0);
    expect_out("same_cyc", 1, 0, 32'h110, 1, 1, 1, 32'h120, 12, 6);
    drive(0, 1, 32'h10C, BEQ | 32'h4, 1, 32'h10C, ADD, 3, 3, 1);
    expect_out("ex_add", 1, 1, 32'h120, 0, 0, 0, 32'h110, 13, 7);
    drive(0, 1, 32'h10C, BEQ | 32'h4, 0, 32'h10C, BEQ | 32'h4, 0, 0, 1);
    expect_out("ex_invalid", 1, 1, 32'h120, 0, 0, 0, 32'h110, 13, 7);
    drive(0, 1, 32'h10C, BEQ | 32'h4, 0, 0, 0, 0, 0, 0);
    expect_out("no_train", 1, 1, 32'h120, 0, 0, 0, 32'h4, 13, 7);
    drive(0, 1, 32'h10C, ADD, 0, 0, 0, 0, 0, 0);
    expect_out("if_add", 0, 0, 32'h110, 0, 0, 0, 32'h4, 13, 7);
    // 20 mispredicts on index 12: 4-bit counters saturate at 0xF.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1, 32'h130, BEQ | 32'h4, 9, 9, 0);
      expect_out("sat_cnt", 0, 0, 32'h4, 1, 1, 1, 32'h144,
                 (13 + i > 15) ? 15 : 13 + i, (7 + i > 15) ? 15 : 7 + i);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("cnt_full", 0, 0, 32'h4, 0, 0, 0, 32'h4, 15, 15);
    // Mid-stream reset: pre-edge outputs still show history, then everything is wiped.
    drive(1, 1, 32'h11C, BEQ | 32'hFFFF, 0, 0, 0, 0, 0, 0);
    expect_out("mid_rst", 1, 1, 32'h11C, 0, 0, 0, 32'h4, 15, 15);
    drive(0, 1, 32'h11C, BEQ | 32'hFFFF, 0, 0, 0, 0, 0, 0);
    expect_out("post_rst7", 1, 0, 32'h120, 0, 0, 0, 32'h4, 0, 0);
    drive(0, 1, 32'h200, BEQ | 32'hFFFF, 0, 0, 0, 0, 0, 0);
    expect_out("post_rst0", 1, 0, 32'h204, 0, 0, 0, 32'h4, 0, 0);
    drive(0, 1, 32'h10C, BEQ | 32'h4, 0, 0, 0, 0, 0, 0);
    expect_out("post_rst3", 1, 0, 32'h110, 0, 0, 0, 32'h4, 0, 0);
    drive(0, 1, 32'h100, BEQ | 32'h4, 0, 0, 0, 0, 0, 0);
    expect_out("post_rst0b", 1, 0, 32'h104, 0, 0, 0, 32'h4, 0, 0);
    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised branch unit combining fetch-stage prediction with EX-stage resolution for the MIPS pipeline. A direct-mapped branch history table (BHT) of 2-bit saturating counters predicts taken or not-taken for BEQ, BNE, BLEZ, BGTZ, BLTZ and BGEZ at fetch. At EX the unit evaluates the branch condition, trains the BHT, raises a mispredict and supplies the corrected PC. It also keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
DATA_W, 32, register operand width (RS/RT)
PC_W, 32, program counter width
BHT_DEPTH, 64, BHT entries; power of 2, minimum 2
IDX_W, log2(BHT_DEPTH), BHT index width (derived)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
if_valid  in  1  fetch-stage instruction valid
if_pc  in  PC_W  fetch-stage PC
if_instr  in  32  fetch-stage instruction
if_is_branch  out  1  fetch instruction is a supported conditional branch
if_pred_taken  out  1  prediction for fetch instruction
if_pred_target  out  PC_W  predicted next PC for fetch instruction
ex_valid  in  1  EX-stage instruction valid (0 during bubbles/flush)
ex_pc  in  PC_W  EX-stage PC
ex_instr  in  32  EX-stage instruction
ex_rs  in  DATA_W  forwarded RS value
ex_rt  in  DATA_W  forwarded RT value
ex_pred_taken  in  1  prediction piped down from fetch
ex_is_branch  out  1  EX instruction is a supported branch and ex_valid
ex_taken  out  1  resolved branch outcome
mispredict  out  1  flush request; resolved outcome differs from prediction
redirect_pc  out  PC_W  correct next PC, valid when mispredict=1
branch_count  out  CNT_W  resolved branches since reset
mispredict_count  out  CNT_W  mispredicts since reset

Behaviour:
- Decode: op=instr[31:26]. BEQ 0x04, BNE 0x05, BLEZ 0x06, BGTZ 0x07; REGIMM op 0x01 with instr[20:16]=0x00 is BLTZ, =0x01 is BGEZ. All other encodings are non-branch.
- Conditions (two's complement, DATA_W bits): BEQ rs==rt; BNE rs!=rt; BLEZ rs[MSB] | rs==0; BGTZ !rs[MSB] & rs!=0; BLTZ rs[MSB]; BGEZ !rs[MSB].
- Target = pc + 4 + (sign-extended instr[15:0] << 2), computed modulo 2^PC_W. Fall-through = pc + 4, wrapping modulo 2^PC_W.
- BHT index = pc[IDX_W+1:2]. Each entry is a 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff counter[1]=1.
- Fetch path is combinational from BHT registers. if_pred_taken = if_valid & if_is_branch & counter[1]. if_pred_target = target if if_pred_taken, else if_pc+4. Non-branch or invalid fetch gives if_pred_taken=0.
- EX path is combinational. ex_is_branch = ex_valid & decoded branch. ex_taken = ex_is_branch & condition. mispredict = ex_is_branch & (ex_taken != ex_pred_taken). redirect_pc = target if ex_taken, else ex_pc+4.
- Training happens at the clock edge when ex_is_branch=1. The entry at index(ex_pc) increments if taken and decrements if not. It saturates at 11 and 00.
- Same-cycle fetch read and EX write to the same index: fetch sees the pre-update value. There is no bypass.
- Statistics: branch_count increments when ex_is_branch=1. mispredict_count increments when mispredict=1. Both saturate at all-ones and do not wrap.
- Reset (synchronous, every edge while reset=1): all BHT entries = 01, branch_count=0, mispredict_count=0. Training and counting are suppressed in a reset cycle.
- Outputs during reset: combinational outputs follow their inputs, with the BHT read as 01 after the first reset edge.
- Reset asserted mid-operation discards all history; the first prediction after release is not-taken.
- Latency: prediction 0 cycles, resolution 0 cycles, training visible to fetch 1 cycle after the EX edge.

Test Plan:
1. Reset, then fetch BEQ at pc=0x100 with imm=0x0004 -> if_is_branch=1, if_pred_taken=0, if_pred_target=0x104; counters=0.
2. EX BEQ pc=0x100, rs=rt=5, ex_pred_taken=0 -> ex_taken=1, mispredict=1, redirect_pc=0x114. Next cycle BHT[0] reads 10, and fetch of pc=0x100 gives if_pred_taken=1 with target 0x114.
3. Conditions on DATA_W=32: BGTZ rs=0 -> not taken; BLEZ rs=0 -> taken; BLTZ rs=0x80000000 -> taken; BGEZ rs=0 -> taken; BNE rs=1,rt=2 -> taken.
4. Four consecutive taken resolutions then one not-taken on one index -> counter 01→10→11→11→11→10, still predicts taken. Negative imm=0xFFFF at pc=0x200 gives target 0x200.
5. Same-cycle EX write and fetch read on index 3 -> fetch sees old value. Non-branch ex_instr (ADD) with ex_valid=1, or any branch with ex_valid=0 -> no training, no count, mispredict=0.
6. CNT_W=4: 20 mispredicted branches -> both counters hold 0xF. Then assert reset mid-stream for one cycle -> counters=0 and all entries 01.
